// File: rtl/branch_predictor_bht.sv
// -----------------------------------------------------------------------------
// branch_predictor_bht
//
// Branch history table of ENTRIES saturating counters. The table can be
// indexed from the PC alone (bimodal) or from the PC XORed with a global
// history register (gshare). The block also forms the branch target address
// and keeps saturating counts of resolved and mispredicted branches.
//
// The lookup side is purely combinational and serves the decode stage. The
// update side is registered and driven by the MEM-stage branch resolution.
//
// Ports
//   clk               rising-edge clock
//   rst_n             asynchronous active-low reset
//   lookup_valid      decode-stage instruction is a conditional branch
//   lookup_pc         PC of the decode-stage instruction
//   lookup_offset     sign-extended branch immediate
//   prediction        predict taken (0 when lookup_valid is low)
//   branch_addr       lookup_pc + lookup_offset, modulo 2^ADDR_W
//   lookup_idx        table index used by this lookup; travels down the pipe
//   update_valid      MEM-stage resolved conditional branch
//   update_idx        index that was used when this branch was looked up
//   update_taken      actual branch outcome
//   update_mispredict the prediction for this branch was wrong
//   ghr               current global history (reads 0 in bimodal mode)
//   branch_cnt        resolved branches, saturating
//   mispredict_cnt    mispredicted branches, saturating
// -----------------------------------------------------------------------------
module branch_predictor_bht #(
   parameter int  ENTRIES = 16,
   parameter int  CTR_W   = 2,
   parameter int  ADDR_W  = 32,
   parameter int  GHR_W   = 0,
   parameter int  PERF_W  = 32,
   localparam int IDX_W   = $clog2(ENTRIES),
   localparam int GHR_OW  = (GHR_W > 0) ? GHR_W : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              lookup_valid,
   input  logic [ADDR_W-1:0] lookup_pc,
   input  logic [ADDR_W-1:0] lookup_offset,
   output logic              prediction,
   output logic [ADDR_W-1:0] branch_addr,
   output logic [IDX_W-1:0]  lookup_idx,
   input  logic              update_valid,
   input  logic [IDX_W-1:0]  update_idx,
   input  logic              update_taken,
   input  logic              update_mispredict,
   output logic [GHR_OW-1:0] ghr,
   output logic [PERF_W-1:0] branch_cnt,
   output logic [PERF_W-1:0] mispredict_cnt
);

   // Weakly-not-taken: one below the taken threshold (MSB set).
   localparam logic [CTR_W-1:0] CTR_RST = CTR_W'((1 << (CTR_W - 1)) - 1);

   // Saturating up/down step of a prediction counter.
   function automatic logic [CTR_W-1:0] ctr_step(input logic [CTR_W-1:0] c,
                                                 input logic             up);
      logic [CTR_W-1:0] r;
      r = c;
      if (up) begin
         if (c != {CTR_W{1'b1}}) r = c + CTR_W'(1);
      end else begin
         if (c != {CTR_W{1'b0}}) r = c - CTR_W'(1);
      end
      return r;
   endfunction

   // Saturating increment of a performance counter; sticks at all-ones.
   function automatic logic [PERF_W-1:0] perf_inc(input logic [PERF_W-1:0] c);
      logic [PERF_W-1:0] r;
      r = c;
      if (c != {PERF_W{1'b1}}) r = c + PERF_W'(1);
      return r;
   endfunction

   logic [CTR_W-1:0]  bht_q [ENTRIES];
   logic [CTR_W-1:0]  bht_d [ENTRIES];
   logic [PERF_W-1:0] branch_cnt_q;
   logic [PERF_W-1:0] branch_cnt_d;
   logic [PERF_W-1:0] mispredict_cnt_q;
   logic [PERF_W-1:0] mispredict_cnt_d;
   logic [IDX_W-1:0]  base_idx;

   // Word-aligned PC bits select the entry; bits [1:0] are always zero.
   assign base_idx = lookup_pc[IDX_W+1:2];

   // --------------------------------------------------------------------------
   // Global history and index formation
   // --------------------------------------------------------------------------
   if (GHR_W > 0) begin : g_gshare
      logic [GHR_W-1:0] ghr_q;
      logic [GHR_W-1:0] ghr_d;

      // History only shifts on resolution, never speculatively. A shift
      // rather than a part-select keeps GHR_W=1 legal.
      always_comb begin
         ghr_d = ghr_q;
         if (update_valid) begin
            ghr_d = (ghr_q << 1) | GHR_W'(update_taken);
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            ghr_q <= '0;
         end else begin
            ghr_q <= ghr_d;
         end
      end

      assign ghr        = ghr_q;
      assign lookup_idx = base_idx ^ IDX_W'(ghr_q);
   end else begin : g_bimodal
      assign ghr        = '0;
      assign lookup_idx = base_idx;
   end

   // --------------------------------------------------------------------------
   // Lookup: combinational, reads the table state before any same-cycle update
   // --------------------------------------------------------------------------
   assign prediction  = lookup_valid & bht_q[lookup_idx][CTR_W-1];
   assign branch_addr = lookup_pc + lookup_offset;

   // --------------------------------------------------------------------------
   // Update: table counter and performance counters
   // --------------------------------------------------------------------------
   always_comb begin
      bht_d = bht_q;
      if (update_valid) begin
         bht_d[update_idx] = ctr_step(bht_q[update_idx], update_taken);
      end
   end

   always_comb begin
      branch_cnt_d     = branch_cnt_q;
      mispredict_cnt_d = mispredict_cnt_q;
      if (update_valid) begin
         branch_cnt_d = perf_inc(branch_cnt_q);
         if (update_mispredict) begin
            mispredict_cnt_d = perf_inc(mispredict_cnt_q);
         end
      end
   end

   // Table lives in flops so every entry can be reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            bht_q[i] <= CTR_RST;
         end
      end else begin
         for (int i = 0; i < ENTRIES; i++) begin
            bht_q[i] <= bht_d[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         branch_cnt_q     <= '0;
         mispredict_cnt_q <= '0;
      end else begin
         branch_cnt_q     <= branch_cnt_d;
         mispredict_cnt_q <= mispredict_cnt_d;
      end
   end

   assign branch_cnt     = branch_cnt_q;
   assign mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor_bht
//
// Three predictors share one stimulus stream: bimodal (b), gshare with a
// 4-bit history (g) and a bimodal copy with 4-bit performance counters (p).
// The reference model holds the table as plain integers clamped to 0..3,
// the history as an integer modulo 16 and the counts as unbounded integers.
// -----------------------------------------------------------------------------
module tb_branch_predictor_bht;

   logic        clk;
   logic        rst_n;
   logic        lookup_valid;
   logic [31:0] lookup_pc;
   logic [31:0] lookup_offset;
   logic        update_valid;
   logic [3:0]  update_idx;
   logic        update_taken;
   logic        update_mispredict;

   logic        pred_b, pred_g, pred_p;
   logic [31:0] addr_b, addr_g, addr_p;
   logic [3:0]  idx_b, idx_g, idx_p;
   logic [0:0]  ghr_b, ghr_p;
   logic [3:0]  ghr_g;
   logic [31:0] bcnt_b, mcnt_b, bcnt_g, mcnt_g;
   logic [3:0]  bcnt_p, mcnt_p;

   branch_predictor_bht #(.ENTRIES(16), .CTR_W(2), .ADDR_W(32), .GHR_W(0), .PERF_W(32)) u_bim (
      .clk(clk), .rst_n(rst_n), .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
      .lookup_offset(lookup_offset), .prediction(pred_b), .branch_addr(addr_b),
      .lookup_idx(idx_b), .update_valid(update_valid), .update_idx(update_idx),
      .update_taken(update_taken), .update_mispredict(update_mispredict),
      .ghr(ghr_b), .branch_cnt(bcnt_b), .mispredict_cnt(mcnt_b));

   branch_predictor_bht #(.ENTRIES(16), .CTR_W(2), .ADDR_W(32), .GHR_W(4), .PERF_W(32)) u_gsh (
      .clk(clk), .rst_n(rst_n), .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
      .lookup_offset(lookup_offset), .prediction(pred_g), .branch_addr(addr_g),
      .lookup_idx(idx_g), .update_valid(update_valid), .update_idx(update_idx),
      .update_taken(update_taken), .update_mispredict(update_mispredict),
      .ghr(ghr_g), .branch_cnt(bcnt_g), .mispredict_cnt(mcnt_g));

   branch_predictor_bht #(.ENTRIES(16), .CTR_W(2), .ADDR_W(32), .GHR_W(0), .PERF_W(4)) u_p4 (
      .clk(clk), .rst_n(rst_n), .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
      .lookup_offset(lookup_offset), .prediction(pred_p), .branch_addr(addr_p),
      .lookup_idx(idx_p), .update_valid(update_valid), .update_idx(update_idx),
      .update_taken(update_taken), .update_mispredict(update_mispredict),
      .ghr(ghr_p), .branch_cnt(bcnt_p), .mispredict_cnt(mcnt_p));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   int tbl [16];
   int hist;
   int bcnt;
   int mcnt;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] off;
      logic [31:0] addr;
      logic [3:0]  idx;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) tbl[i] = 1;
      hist = 0;
      bcnt = 0;
      mcnt = 0;
   endtask

   task automatic model_update(input int idx, input bit taken, input bit mis);
      if (taken) tbl[idx] = (tbl[idx] >= 3) ? 3 : tbl[idx] + 1;
      else       tbl[idx] = (tbl[idx] <= 0) ? 0 : tbl[idx] - 1;
      hist = (hist * 2 + (taken ? 1 : 0)) % 16;
      bcnt = bcnt + 1;
      if (mis) mcnt = mcnt + 1;
   endtask

   function automatic int m_base(input logic [31:0] pc);
      return int'((pc / 4) % 16);
   endfunction

   // Compare the combinational lookup outputs of all instances with the model.
   task automatic check_comb(input string tag);
      int          ib, ig;
      logic [31:0] ea;
      ib = m_base(lookup_pc);
      ig = ib ^ hist;
      ea = lookup_pc + lookup_offset;
      check({tag, "_idx_b"},  64'(idx_b),  64'(ib));
      check({tag, "_idx_g"},  64'(idx_g),  64'(ig));
      check({tag, "_pred_b"}, 64'(pred_b), 64'(lookup_valid && tbl[ib] >= 2));
      check({tag, "_pred_g"}, 64'(pred_g), 64'(lookup_valid && tbl[ig] >= 2));
      check({tag, "_pred_p"}, 64'(pred_p), 64'(lookup_valid && tbl[ib] >= 2));
      check({tag, "_addr_b"}, 64'(addr_b), 64'(ea));
      check({tag, "_addr_g"}, 64'(addr_g), 64'(ea));
   endtask

   task automatic check_state(input string tag);
      check({tag, "_bcnt_b"}, 64'(bcnt_b), 64'(bcnt));
      check({tag, "_mcnt_b"}, 64'(mcnt_b), 64'(mcnt));
      check({tag, "_bcnt_g"}, 64'(bcnt_g), 64'(bcnt));
      check({tag, "_bcnt_p"}, 64'(bcnt_p), 64'((bcnt > 15) ? 15 : bcnt));
      check({tag, "_mcnt_p"}, 64'(mcnt_p), 64'((mcnt > 15) ? 15 : mcnt));
      check({tag, "_ghr_g"},  64'(ghr_g),  64'(hist));
      check({tag, "_ghr_b"},  64'(ghr_b),  64'(0));
   endtask

   // Advance one clock; inputs are captured at the edge and mirrored in the model.
   task automatic step();
      bit uv, ut, um;
      int ui;
      uv = update_valid;
      ut = update_taken;
      um = update_mispredict;
      ui = int'(update_idx);
      @(posedge clk);
      if (uv && rst_n) model_update(ui, ut, um);
      #1;
   endtask

   task automatic upd(input int idx, input bit taken, input bit mis);
      update_valid      = 1'b1;
      update_idx        = 4'(idx);
      update_taken      = taken;
      update_mispredict = mis;
      step();
      update_valid      = 1'b0;
      update_mispredict = 1'b0;
   endtask

   task automatic lookup(input logic [31:0] pc);
      lookup_valid = 1'b1;
      lookup_pc    = pc;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      update_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0] = '{pc: 32'hFFFF_FFFC, off: 32'h0000_0008, addr: 32'h0000_0004, idx: 4'hF};
      vecs[1] = '{pc: 32'h0000_0100, off: 32'hFFFF_FFF8, addr: 32'h0000_00F8, idx: 4'h0};
      vecs[2] = '{pc: 32'h0000_0040, off: 32'h0000_0010, addr: 32'h0000_0050, idx: 4'h0};
      vecs[3] = '{pc: 32'h0000_0014, off: 32'hFFFF_FFFC, addr: 32'h0000_0010, idx: 4'h5};
      vecs[4] = '{pc: 32'h8000_0000, off: 32'h8000_0000, addr: 32'h0000_0000, idx: 4'h0};
      vecs[5] = '{pc: 32'h0000_003C, off: 32'h0000_0000, addr: 32'h0000_003C, idx: 4'hF};
      vecs[6] = '{pc: 32'h1234_5678, off: 32'h0000_1000, addr: 32'h1234_6678, idx: 4'hE};

      rst_n             = 1'b0;
      lookup_valid      = 1'b0;
      lookup_pc         = '0;
      lookup_offset     = '0;
      update_valid      = 1'b0;
      update_idx        = '0;
      update_taken      = 1'b0;
      update_mispredict = 1'b0;
      model_reset();
      do_reset();

      // Reset state: counters, history and every entry weakly not-taken.
      check_state("rst");
      for (int i = 0; i < 16; i++) begin
         lookup(32'(i * 4));
         check("rst_pred_entry", 64'(pred_b), 64'(0));
      end

      // Address and index vectors, with lookup_valid low: prediction stays 0.
      for (int i = 0; i < 7; i++) begin
         lookup_valid  = 1'b0;
         lookup_pc     = vecs[i].pc;
         lookup_offset = vecs[i].off;
         #1;
         check("vec_addr", 64'(addr_b), 64'(vecs[i].addr));
         check("vec_addr_p", 64'(addr_p), 64'(vecs[i].addr));
         check("vec_idx", 64'(idx_b), 64'(vecs[i].idx));
         check("vec_pred_novalid", 64'(pred_b), 64'(0));
      end
      lookup_offset = '0;

      // Fresh table, pc 0x40.
      lookup(32'h40);
      check("tp1_pred", 64'(pred_b), 64'(0));
      check("tp1_idx", 64'(idx_b), 64'(0));

      // Same-cycle update and lookup at idx 5: old value seen, new one next cycle.
      update_valid = 1'b1; update_idx = 4'd5; update_taken = 1'b1; update_mispredict = 1'b0;
      lookup(32'h14);
      check("tp3_pred_same_cycle", 64'(pred_b), 64'(0));
      check_comb("tp3a");
      step();
      update_valid = 1'b0;
      #1;
      check("tp3_pred_next_cycle", 64'(pred_b), 64'(1));
      check_comb("tp3b");

      // Saturation of entry 0; pc 0x80 aliases onto it.
      upd(0, 1, 0);
      upd(0, 1, 0);
      lookup(32'h80);
      check("tp2_pred_alias", 64'(pred_b), 64'(1));
      for (int i = 0; i < 5; i++) upd(0, 1, 0);
      upd(0, 0, 0);
      lookup(32'h80);
      check("tp2_pred_after_dec", 64'(pred_b), 64'(1));
      check("tp2_model_ctr", 64'(tbl[0]), 64'(2));
      check_comb("tp2");
      check_state("tp2");

      // Gshare history T,T,N,T.
      do_reset();
      upd(7, 1, 0);
      upd(7, 1, 0);
      upd(7, 0, 0);
      upd(7, 1, 0);
      check("tp5_ghr", 64'(ghr_g), 64'hD);
      lookup(32'h0);
      check("tp5_idx_g", 64'(idx_g), 64'hD);
      check("tp5_idx_b", 64'(idx_b), 64'h0);
      check_comb("tp5");

      // Performance counts, then asynchronous reset in the middle of an update.
      do_reset();
      upd(3, 1, 0);
      upd(3, 1, 1);
      upd(3, 1, 0);
      check("tp6_bcnt", 64'(bcnt_b), 64'(3));
      check("tp6_mcnt", 64'(mcnt_b), 64'(1));
      check_state("tp6");
      update_valid = 1'b1; update_idx = 4'd3; update_taken = 1'b1; update_mispredict = 1'b1;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      model_reset();
      check("tp6_async_bcnt", 64'(bcnt_b), 64'(0));
      check("tp6_async_mcnt", 64'(mcnt_b), 64'(0));
      check("tp6_async_ghr", 64'(ghr_g), 64'(0));
      lookup(32'hC);
      check("tp6_async_pred", 64'(pred_b), 64'(0));
      @(posedge clk);
      #1;
      check("tp6_held_bcnt", 64'(bcnt_b), 64'(0));
      update_valid = 1'b0;
      update_mispredict = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      upd(3, 1, 0);
      lookup(32'hC);
      check("tp6_entry_reset_val", 64'(pred_b), 64'(1));
      check_comb("tp6");
      check_state("tp6r");

      // 4-bit counters saturate at 15.
      do_reset();
      for (int i = 0; i < 17; i++) upd(i % 16, i[0], 1);
      check("perf4_bcnt", 64'(bcnt_p), 64'(15));
      check("perf4_mcnt", 64'(mcnt_p), 64'(15));
      check("perf32_bcnt", 64'(bcnt_b), 64'(17));
      check_state("perf4");

      // Random traffic against the model.
      do_reset();
      for (int n = 0; n < 400; n++) begin
         lookup_valid      = 1'($urandom_range(0, 1));
         lookup_pc         = $urandom;
         lookup_offset     = $urandom;
         update_valid      = ($urandom_range(0, 3) != 0);
         update_idx        = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
         update_taken      = ($urandom_range(0, 2) != 0);
         update_mispredict = 1'($urandom_range(0, 1));
         #1;
         check_comb("rnd");
         step();
         check_state("rnd");
      end
      update_valid = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
